// File: rtl/sid_pot_emu_if.sv
// sid_pot_emu_if: pad, paddle-value and status signals between host side and pot emulator
interface sid_pot_emu_if;
  logic       clk_en;
  logic       pad;
  logic [7:0] pot_val;
  logic       pad_oe;
  logic       sync;
  logic       busy;
  modport master (output clk_en, pad, pot_val, input pad_oe, sync, busy);
  modport slave  (input clk_en, pad, pot_val, output pad_oe, sync, busy);
endinterface

// File: rtl/sid_pot_emu.sv
// sid_pot_emu: answers a SID pot-measurement discharge by holding the pad low for the
// programmed paddle value, so the measuring side reads that value.
module sid_pot_emu #(
  parameter int MIN_LOW  = 128,
  parameter int LAT_COMP = 2,
  parameter int SETTLE   = 4
) (
  input logic          clk,
  input logic          rst,
  sid_pot_emu_if.slave bus
);
  typedef enum logic [1:0] {WAIT_LOW, HOST_LOW, HOLD, RECOVER} state_t;
  state_t     state, state_n;
  logic       pad_m, pad_s;
  logic [7:0] low_cnt, low_cnt_n, hold_cnt, hold_cnt_n, v, v_n, v_new, set_cnt, set_cnt_n;
  logic       sync_n;
  always_ff @(posedge clk) begin
    if (rst) {pad_m, pad_s} <= 2'b11;
    else     {pad_m, pad_s} <= {bus.pad, pad_m};
  end
  always_comb begin
    state_n    = state;
    low_cnt_n  = low_cnt;
    hold_cnt_n = hold_cnt;
    v_n        = v;
    set_cnt_n  = '0;
    sync_n     = 1'b0;
    v_new      = (32'(bus.pot_val) > LAT_COMP) ? bus.pot_val - 8'(LAT_COMP) : 8'd0;
    case (state)
      WAIT_LOW: if (!pad_s) begin
        state_n   = HOST_LOW;
        low_cnt_n = 8'd1;
      end
      HOST_LOW: if (!pad_s) low_cnt_n = (&low_cnt) ? low_cnt : low_cnt + 8'd1;
        else if (32'(low_cnt) >= MIN_LOW) begin
          v_n        = v_new;
          hold_cnt_n = '0;
          sync_n     = 1'b1;
          state_n    = (v_new == 8'd0) ? RECOVER : HOLD;
        end else state_n = WAIT_LOW;
      HOLD: begin
        hold_cnt_n = hold_cnt + 8'd1;
        state_n    = (hold_cnt + 8'd1 == v) ? RECOVER : HOLD;
      end
      RECOVER: begin
        set_cnt_n = set_cnt + 8'd1;
        state_n   = (set_cnt == 8'(SETTLE - 1)) ? WAIT_LOW : RECOVER;
      end
    endcase
  end
  // sync is a single clk pulse, so it clears even on ticks without clk_en
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_LOW;
      low_cnt    <= '0;
      hold_cnt   <= '0;
      v          <= '0;
      set_cnt    <= '0;
      bus.pad_oe <= 1'b0;
      bus.sync   <= 1'b0;
      bus.busy   <= 1'b0;
    end else if (bus.clk_en) begin
      state      <= state_n;
      low_cnt    <= low_cnt_n;
      hold_cnt   <= hold_cnt_n;
      v          <= v_n;
      set_cnt    <= set_cnt_n;
      bus.pad_oe <= state_n == HOLD;
      bus.sync   <= sync_n;
      bus.busy   <= state_n == HOLD || state_n == RECOVER;
    end else bus.sync <= 1'b0;
  end
endmodule

// File: doc/sid_pot_emu.md
# sid_pot_emu

Paddle/potentiometer emulator for the SID POTX/POTY lines: the responder for the SID's pot-measurement cycle. An external SID, or our own measuring logic on another pad, discharges the shared line for 256 phi2 cycles and then releases it. This block then holds the line low for a programmable number of phi2 cycles before letting the external pull-up raise it, so the measuring side reads the requested 8-bit paddle value. It sits between the paddle register file and the pad cell; the pad tri-state itself is outside this block.

## Interface

Parameters:
- `MIN_LOW`, default 128: minimum host-discharge length in clkEn ticks for a release to count as a valid measurement start.
- `LAT_COMP`, default 2: ticks subtracted from the programmed value to cancel the synchroniser and pad latency. Saturates at 0.
- `SETTLE`, default 4: ticks the input is ignored after this block releases the line.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `clkEn` in 1: phi2 tick enable. All state, counter and output updates occur only when `clkEn` is high.
- `iPadIn` in 1: raw pad level, asynchronous.
- `iPotVal` in 8: requested paddle value. Sampled once per measurement.
- `oPadOe` out 1: registered. 1 means the pad drives 0; 0 means high-Z.
- `oSync` out 1: one-clk pulse when a valid host release is accepted.
- `oBusy` out 1: high while in HOLD or RECOVER.

## Operation

- **Synchroniser:**
  - Two-flop synchroniser on `iPadIn` runs every `clk`, independent of `clkEn`.
  - Its output `pad_s` is the only pad view used by the block.
- **States:** WAIT_LOW, HOST_LOW, HOLD, RECOVER.
- **WAIT_LOW:**
  - `oPadOe`=0.
  - If `pad_s`=0: go to HOST_LOW and set `low_cnt`=1.
- **HOST_LOW:**
  - `oPadOe`=0.
  - If `pad_s`=0: `low_cnt` increments, saturating at 255.
  - If `pad_s`=1 and `low_cnt` >= `MIN_LOW` (valid release):
    - latch `v` = sat0(`iPotVal` − `LAT_COMP`), clear `hold_cnt`, pulse `oSync`;
    - if `v`=0, go to RECOVER; otherwise go to HOLD.
  - If `pad_s`=1 and `low_cnt` < `MIN_LOW`: glitch. Return to WAIT_LOW; `oSync` stays 0.
- **HOLD:**
  - `oPadOe`=1.
  - Each tick `hold_cnt` increments.
  - When `hold_cnt`+1 == `v`: go to RECOVER and set `oPadOe`=0 on that edge.
  - The input is ignored during HOLD.
- **RECOVER:**
  - `oPadOe`=0.
  - Count `SETTLE` ticks, then go to WAIT_LOW.
  - The input is ignored, which masks the synchroniser lag after our own release.
- **Counter widths:** `low_cnt`, `hold_cnt` and `v` are 8 bits. The `hold_cnt` compare is exact, so no wrap occurs (`v` ≤ 255).
- **Value changes:** a change of `iPotVal` during HOLD has no effect. The new value applies at the next valid release.

## Timing

- **Reset values:**
  - state = WAIT_LOW; `oPadOe`=0, `oSync`=0, `oBusy`=0; all counters 0.
  - Synchroniser flops reset to 1 (line idle high).
- Reset overrides `clkEn`.
- Reset during HOLD releases the pad (`oPadOe`=0) on the same clock edge.
- **Release-to-drive latency:**
  - The pad rise appears on `pad_s` 2 clk later.
  - `oPadOe` rises on the first `clkEn` edge at which `pad_s`=1 in HOST_LOW.
- **Hold length:** `oPadOe` is high for exactly `v` consecutive `clkEn` ticks.
- **`oSync`:** asserted for one `clk` cycle, on the same edge as entry into HOLD or RECOVER from HOST_LOW.
- **`oBusy`:** equals (state ∈ {HOLD, RECOVER}), registered.
- **`clkEn` low:** all state, counters and outputs hold, except the synchroniser and the `oSync` clear.
- **Host re-discharge during HOLD** (a short host cycle) is not detected. The block finishes HOLD and RECOVER, then resynchronises in WAIT_LOW.

## Test plan

- **Nominal:** clkEn every cycle, `LAT_COMP`=2, `iPotVal`=100. Host drives low for 256 ticks, then releases to pull-up.
  - `oSync` pulses once.
  - `oPadOe` is high for exactly 98 ticks; `oBusy` spans HOLD+RECOVER (98+4 ticks).
  - Host-side charge counter reads 100.
- **Zero and saturation:** `iPotVal`=1 (`v`=0 after compensation) → no HOLD, `oPadOe` never asserts, `oSync` still pulses. `iPotVal`=255 → `oPadOe` high for 253 ticks.
- **Glitch rejection:** pad low for 50 ticks (< `MIN_LOW`) then high → state returns to WAIT_LOW, `oSync`=0, `oPadOe`=0.
- **Value change mid-hold:** `iPotVal` changes 10→200 during HOLD → current hold is 8 ticks; next measurement holds 198 ticks.
- **Reset mid-HOLD:** assert `rst` for 1 clk at `hold_cnt`=30 → `oPadOe`=0 on that edge, state WAIT_LOW. The next valid host cycle works normally.
- **Sparse clkEn:** clkEn 1-in-8 cycles with `iPotVal`=50 → `oPadOe` high for exactly 48 clkEn ticks (384 clk), all transitions aligned to clkEn edges.
